// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the 68k-side SRAM bus-cycle responder.
// The BERR state and bus-error output bit exist only when SRAM_RESP_BERR_EN is defined.
package sram_resp_pkg;

    localparam int NUM_BLOCKS  = 4;
    localparam int SRAM_ADDR_W = 15;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        ACK,
        RECOVER
`ifdef SRAM_RESP_BERR_EN
        , BERR
`endif
    } state_e;

    // Bus-cycle attributes captured on the start edge.
    typedef struct packed {
        logic [NUM_BLOCKS-1:0]  blk;
        logic                   rd;
        logic                   uds_l;
        logic                   lds_l;
        logic [SRAM_ADDR_W-1:0] addr;
    } cycle_t;

    typedef struct packed {
        logic [NUM_BLOCKS-1:0] ce_l;
        logic                  oe_l;
        logic                  we_l;
        logic                  ub_l;
        logic                  lb_l;
        logic                  dtack_l;
`ifdef SRAM_RESP_BERR_EN
        logic                  berr_l;
`endif
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '1;

    function automatic logic is_one_hot(input logic [NUM_BLOCKS-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the SRAM access; zero_o flags the last wait cycle.
module sram_wait_counter
    import sram_resp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  zero_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;

    // NOTE: flops update with <= so every register samples pre-edge values; = here would race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_responder.sv
// 68000 bus-cycle responder for the SRAM array: registered CE/OE/WE/byte lanes and DtAck_L.
// Define SRAM_RESP_BERR_EN to add the BErr_L port and bus-error response to bad block selects.
module sram_bus_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                   Clock,
    input  logic                   Reset_L,
    input  logic                   AS_L,
    input  logic                   UDS_L,
    input  logic                   LDS_L,
    input  logic                   WE_L,
    input  logic [16:0]            Address,
    input  logic                   SRamSelect_H,
    input  logic [NUM_BLOCKS-1:0]  Block_H,
    output logic [NUM_BLOCKS-1:0]  SRam_CE_L,
    output logic                   SRam_OE_L,
    output logic                   SRam_WE_L,
    output logic                   SRam_UB_L,
    output logic                   SRam_LB_L,
    output logic [SRAM_ADDR_W-1:0] SRam_Addr,
    output logic                   DtAck_L
`ifdef SRAM_RESP_BERR_EN
    ,
    output logic                   BErr_L
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES - 1);

    state_e   state_q, state_d;
    cycle_t   cyc_q, cyc_d;
    bus_out_t out_q, out_d;
    logic     cnt_load, cnt_dec, cnt_zero;
    logic     start_req;
    logic     unused_addr;

    assign unused_addr = ^Address[16:SRAM_ADDR_W];
    assign start_req   = !AS_L && SRamSelect_H && (!UDS_L || !LDS_L);

    sram_wait_counter u_wait_counter (
        .clk        (Clock),
        .rst_n      (Reset_L),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
        state_d  = state_q;
        cyc_d    = cyc_q;
        out_d    = BUS_IDLE;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_req && is_one_hot(Block_H)) begin
                    cyc_d.blk   = Block_H;
                    cyc_d.rd    = WE_L;
                    cyc_d.uds_l = UDS_L;
                    cyc_d.lds_l = LDS_L;
                    cyc_d.addr  = Address[SRAM_ADDR_W-1:0];
                    state_d     = SETUP;
                end
`ifdef SRAM_RESP_BERR_EN
                else if (start_req) begin
                    state_d = BERR;
                end
`endif
            end
            SETUP: begin
                if (AS_L) begin
                    state_d = RECOVER;
                end else begin
                    state_d  = WAIT;
                    cnt_load = 1'b1;
                end
            end
            WAIT: begin
                if (AS_L)          state_d = RECOVER;
                else if (cnt_zero) state_d = ACK;
                else               cnt_dec = 1'b1;
            end
            ACK:     if (AS_L) state_d = RECOVER;
            RECOVER: state_d = IDLE;
`ifdef SRAM_RESP_BERR_EN
            BERR:    if (AS_L) state_d = RECOVER;
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are a function of the state being entered, so they come straight off flops.
        case (state_d)
            SETUP, WAIT, ACK: begin
                out_d.ce_l    = ~cyc_d.blk;
                out_d.ub_l    = cyc_d.uds_l;
                out_d.lb_l    = cyc_d.lds_l;
                out_d.oe_l    = ~cyc_d.rd;
                out_d.we_l    = (state_d == WAIT) ? cyc_d.rd : 1'b1;
                out_d.dtack_l = (state_d != ACK);
            end
`ifdef SRAM_RESP_BERR_EN
            BERR:    out_d.berr_l = (state_q != BERR);
`endif
            default: ;
        endcase
    end

    // NOTE: the latched cycle is reset too, so SRam_Addr reads 0 out of reset rather than X.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            out_q   <= BUS_IDLE;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            out_q   <= out_d;
        end
    end

    assign SRam_CE_L = out_q.ce_l;
    assign SRam_OE_L = out_q.oe_l;
    assign SRam_WE_L = out_q.we_l;
    assign SRam_UB_L = out_q.ub_l;
    assign SRam_LB_L = out_q.lb_l;
    assign SRam_Addr = cyc_q.addr;
    assign DtAck_L   = out_q.dtack_l;
`ifdef SRAM_RESP_BERR_EN
    assign BErr_L    = out_q.berr_l;
`endif

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder (WAIT_STATES=2); BErr_L checks apply when SRAM_RESP_BERR_EN is defined.
module tb_sram_bus_responder;

    logic        Clock = 1'b0;
    logic        Reset_L;
    logic        AS_L, UDS_L, LDS_L, WE_L, SRamSelect_H;
    logic [16:0] Address;
    logic [3:0]  Block_H;
    logic [3:0]  SRam_CE_L;
    logic        SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, DtAck_L;
    logic [14:0] SRam_Addr;
`ifdef SRAM_RESP_BERR_EN
    logic        BErr_L;
`endif

    int checks   = 0;
    int failures = 0;

    sram_bus_responder #(.WAIT_STATES(2)) dut (
        .Clock        (Clock),
        .Reset_L      (Reset_L),
        .AS_L         (AS_L),
        .UDS_L        (UDS_L),
        .LDS_L        (LDS_L),
        .WE_L         (WE_L),
        .Address      (Address),
        .SRamSelect_H (SRamSelect_H),
        .Block_H      (Block_H),
        .SRam_CE_L    (SRam_CE_L),
        .SRam_OE_L    (SRam_OE_L),
        .SRam_WE_L    (SRam_WE_L),
        .SRam_UB_L    (SRam_UB_L),
        .SRam_LB_L    (SRam_LB_L),
        .SRam_Addr    (SRam_Addr),
        .DtAck_L      (DtAck_L)
`ifdef SRAM_RESP_BERR_EN
        ,
        .BErr_L       (BErr_L)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output bundle {CE_L[3:0], OE_L, WE_L, UB_L, LB_L, DtAck_L}.
    function automatic logic [31:0] outs();
        return {23'd0, SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, DtAck_L};
    endfunction

    function automatic logic [31:0] exp_o(input logic [3:0] ce, input logic oe, input logic we,
                                          input logic ub, input logic lb, input logic dt);
        return {23'd0, ce, oe, we, ub, lb, dt};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic bus_idle();
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; WE_L = 1'b1;
        SRamSelect_H = 1'b0; Block_H = 4'b0000; Address = 17'h0;
    endtask

    logic [31:0] all_ones;
    int          we_low;
    logic        oe_seen;

    initial begin
        all_ones = exp_o(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        Reset_L  = 1'b0;
        bus_idle();
        #12;
        check("reset_outputs", outs(), all_ones);
        check("reset_addr", 32'(SRam_Addr), 32'h0);
        Reset_L = 1'b1;
        tick();
        check("idle_after_reset", outs(), all_ones);

        // Word read, block 0, address 0x00123.
        AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; WE_L = 1'b1;
        SRamSelect_H = 1'b1; Block_H = 4'b0001; Address = 17'h00123;
        tick();
        check("rd_e0_outs", outs(), exp_o(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        check("rd_e0_addr", 32'(SRam_Addr), 32'h0123);
        UDS_L = 1'b1; LDS_L = 1'b1; Block_H = 4'b0000; Address = 17'h1FFFF;
        tick();
        check("rd_e1_latched", outs(), exp_o(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        check("rd_e1_addr", 32'(SRam_Addr), 32'h0123);
        tick();
        check("rd_e2_no_ack", outs(), exp_o(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        tick();
        check("rd_e3_ack", outs(), exp_o(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check("rd_ack_hold", outs(), exp_o(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        AS_L = 1'b1;
        tick();
        check("rd_release", outs(), all_ones);
        bus_idle();
        tick();
        check("rd_recover", outs(), all_ones);

        // Upper-byte write, block 2, address 0x1ABCD -> 0x2BCD.
        AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b1; WE_L = 1'b0;
        SRamSelect_H = 1'b1; Block_H = 4'b0100; Address = 17'h1ABCD;
        tick();
        check("wr_e0_outs", outs(), exp_o(4'b1011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
        check("wr_e0_addr", 32'(SRam_Addr), 32'h2BCD);
        we_low  = 0;
        oe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (SRam_WE_L === 1'b0) we_low++;
            if (SRam_OE_L === 1'b0) oe_seen = 1'b1;
            if (DtAck_L === 1'b0) break;
        end
        check("wr_dtack_seen", 32'(DtAck_L), 32'h0);
        check("wr_we_width", 32'(we_low), 32'd2);
        check("wr_we_high_at_ack", outs(), exp_o(4'b1011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        check("wr_oe_never", 32'(oe_seen), 32'h0);
        AS_L = 1'b1;
        tick();
        check("wr_release", outs(), all_ones);

        // Back-to-back: AS_L low again one cycle after negation; this write is then aborted in WAIT.
        AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; WE_L = 1'b0;
        SRamSelect_H = 1'b1; Block_H = 4'b1000; Address = 17'h00456;
        tick();
        check("b2b_dead_cycle", outs(), all_ones);
        tick();
        check("b2b_e0_outs", outs(), exp_o(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        check("b2b_e0_addr", 32'(SRam_Addr), 32'h0456);
        tick();
        check("abort_e1_we", outs(), exp_o(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        check("abort_e2_wait", outs(), exp_o(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        AS_L = 1'b1;
        tick();
        check("abort_released", outs(), all_ones);
        bus_idle();
        tick();
        check("abort_recover", outs(), all_ones);

        // Reset asserted while in ACK.
        AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b1; WE_L = 1'b1;
        SRamSelect_H = 1'b1; Block_H = 4'b0010; Address = 17'h07FFF;
        repeat (4) tick();
        check("rst_pre_ack", outs(), exp_o(4'b1101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        #2 Reset_L = 1'b0;
        #1;
        check("rst_async_outs", outs(), all_ones);
        check("rst_async_addr", 32'(SRam_Addr), 32'h0);
        #2 Reset_L = 1'b1;
        tick();
        check("rst_restart_idle", outs(), exp_o(4'b1101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
        check("rst_restart_addr", 32'(SRam_Addr), 32'h7FFF);
        AS_L = 1'b1;
        tick();
        bus_idle();
        tick();

        // Invalid block select (two bits set).
        AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; WE_L = 1'b1;
        SRamSelect_H = 1'b1; Block_H = 4'b0011; Address = 17'h00010;
        tick();
        check("bad_e0_no_ce", outs(), all_ones);
        tick();
        check("bad_e1_no_ce", outs(), all_ones);
`ifdef SRAM_RESP_BERR_EN
        check("bad_e1_berr", 32'(BErr_L), 32'h0);
`endif
        tick();
        check("bad_e2_no_ack", outs(), all_ones);
`ifdef SRAM_RESP_BERR_EN
        check("bad_e2_berr_hold", 32'(BErr_L), 32'h0);
`endif
        AS_L = 1'b1;
        tick();
`ifdef SRAM_RESP_BERR_EN
        check("bad_berr_release", 32'(BErr_L), 32'h1);
`endif
        tick();
        check("bad_after", outs(), all_ones);

        // Address strobe without SRamSelect_H must not start a cycle.
        AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; WE_L = 1'b1;
        SRamSelect_H = 1'b0; Block_H = 4'b0001; Address = 17'h00200;
        tick();
        tick();
        check("nosel_ignored", outs(), all_ones);
        bus_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bus_responder.md
# sram_bus_responder

Bus-cycle responder for the 68k-side SRAM: the counterpart of the SRAM block decoder. It consumes `SRamSelect_H` and the four one-hot block selects, sequences chip enable, output enable, write enable and byte-lane strobes to the 256 KB SRAM array with a fixed wait-state count, and returns `DtAck_L` to the 68000. It sits between the top-level address decoder/SRAM block decoder and the physical SRAM devices.

## Interface
- `WAIT_STATES`, default 2: number of Clock cycles spent in WAIT; legal range 1–15.
- `Clock` in 1: system clock; all state updates on the rising edge.
- `Reset_L` in 1: asynchronous, active-low reset.
- `AS_L` in 1: 68k address strobe.
- `UDS_L` in 1: 68k upper data strobe.
- `LDS_L` in 1: 68k lower data strobe.
- `WE_L` in 1: 68k R/W line; 1 = read, 0 = write.
- `Address` in 17: 68k A16..A1 plus A0-equivalent (lower 17 bus lines).
- `SRamSelect_H` in 1: top-level decoder says this cycle targets SRAM.
- `Block_H` in 4: block selects 0..3 from the block decoder (one-hot when valid).
- `SRam_CE_L` out 4: per-block chip enable.
- `SRam_OE_L` out 1: SRAM output enable (reads).
- `SRam_WE_L` out 1: SRAM write enable (writes).
- `SRam_UB_L` out 1: SRAM upper byte lane.
- `SRam_LB_L` out 1: SRAM lower byte lane.
- `SRam_Addr` out 15: latched `Address[14:0]`.
- `DtAck_L` out 1: data transfer acknowledge to the 68k.
- `BErr_L` out 1: bus error; present only with `SRAM_RESP_BERR_EN`.

## Operation
- **Reset:** all `_L` outputs are 1, `SRam_Addr` is 0, and the FSM is in IDLE. Reset asserted mid-cycle aborts the cycle immediately: `DtAck_L`, `SRam_WE_L` and all `SRam_CE_L` go to 1 asynchronously.
- **Start condition** (sampled in IDLE): `AS_L`=0, `SRamSelect_H`=1, and `UDS_L`=0 or `LDS_L`=0.
  - On the start edge, latch `Block_H`, `Address[14:0]`, `WE_L`, `UDS_L` and `LDS_L`.
  - For the rest of the cycle, the latched copies drive all SRAM outputs.
- **IDLE → SETUP** on the start edge.
  - Assert `CE_L[k]`=0 for the latched block k.
  - Drive `UB_L`/`LB_L` from the latched `UDS_L`/`LDS_L`.
  - For reads, assert `OE_L`=0.
- **SETUP → WAIT** on the next edge.
  - Load the wait counter with `WAIT_STATES`-1.
  - For writes, assert `WE_L`=0.
- **WAIT:** decrement the counter each edge. When it reaches 0, go to ACK.
- **ACK:**
  - `DtAck_L`=0.
  - `WE_L`=1 on entry, so the write terminates with CE, address and byte lanes still held.
  - `OE_L` remains 0 for reads.
  - Stay in ACK until `AS_L` is sampled 1.
- **ACK → RECOVER:** all SRAM outputs and `DtAck_L` return to 1.
- **RECOVER → IDLE** unconditionally. This gives one guaranteed dead cycle, so back-to-back cycles never merge.
- **`AS_L` negated early** (in SETUP or WAIT): go to RECOVER at once without asserting `DtAck_L`.
- **Strobes changing after start:** ignored; the latched values rule.
- **Invalid block selects:** zero or more than one bit of `Block_H` set at start. The cycle is not started and no CE is asserted. The response is per `SRAM_RESP_BERR_EN`.

## Timing
- Edge 0 is the start edge.
  - CE/OE/UB/LB are valid after edge 0.
  - WE falls after edge 1.
  - `DtAck_L` falls after edge `WAIT_STATES`+1.
- WE low width is `WAIT_STATES` cycles.
- After `AS_L` is sampled high (edge r), `DtAck_L` rises after edge r.
- The next start can be sampled no earlier than edge r+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`SRAM_RESP_BERR_EN` defined:**
  - An invalid block select at the start condition drives `BErr_L`=0 from the next edge.
  - `BErr_L` holds until `AS_L` is sampled 1, then follows with one RECOVER cycle.
  - `DtAck_L` is never asserted in that case.
- **Not defined:** the `BErr_L` port is absent, and invalid selects are silently ignored (the FSM stays in IDLE).

## Structure
- **Shared package `sram_resp_pkg`:**
  - State enum `{IDLE, SETUP, WAIT, ACK, RECOVER}`, plus `BERR` when the feature is enabled.
  - `NUM_BLOCKS`=4.
  - `SRAM_ADDR_W`=15.
  - Wait-counter width constant (4).
- **Sub-module `sram_wait_counter`:** loadable down-counter with a zero flag.
- The FSM and output registers stay in the top module.

## Test plan
- **Word read, `WAIT_STATES`=2, `Block_H`=0001, `Address`=0x00123, both strobes 0:**
  - CE_L=1110, OE_L=0, UB_L=LB_L=0 and `SRam_Addr`=0x0123 after edge 0.
  - `DtAck_L`=0 after edge 3.
  - Everything returns to 1 one edge after `AS_L`=1.
- **Upper-byte write, `Block_H`=0100, `UDS_L`=0, `LDS_L`=1:**
  - UB_L=0, LB_L=1.
  - WE_L=0 for exactly 2 cycles, and returns to 1 when `DtAck_L` falls.
  - OE_L stays 1 throughout.
- **Back-to-back cycles:** `AS_L` re-asserted one cycle after negation. Exactly one RECOVER cycle separates them, and the second cycle latches its new block and address.
- **Abort:** `AS_L` negated while in WAIT. `DtAck_L` is never asserted, and CE/WE return to 1 on the next edge.
- **Reset mid-cycle:** `Reset_L`=0 while in ACK. All outputs go to 1 immediately and the FSM is in IDLE after release.
- **`SRAM_RESP_BERR_EN` set, `Block_H`=0011 with `SRamSelect_H`=1:**
  - `BErr_L`=0 after edge 1.
  - No CE is asserted.
  - Without the macro, the same stimulus gives no response at all.
